// File: rtl/snake_pkg.sv
// Shared encodings for the snake game-flow controller: game states,
// collision codes from the collision detector and the BCD digit width.
package snake_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_PLAY      = 3'b001,
        ST_PAUSE     = 3'b010,
        ST_DYING     = 3'b011,
        ST_GAME_OVER = 3'b111
    } game_state_e;

    localparam logic [1:0] COLL_NONE       = 2'b00;
    localparam logic [1:0] COLLISION       = 2'b01;
    localparam logic [1:0] APPLE_COLLECTED = 2'b10;

    localparam int BCD_W = 4;

    // Code 11 is treated as a collision, so bit 0 alone marks a fatal hit.
    function automatic logic is_collision(input logic [1:0] code);
        return code[0];
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter. Ripple carry is resolved combinationally,
// the score itself is registered. Saturates at all nines instead of wrapping.
module bcd_score_counter
    import snake_pkg::*;
#(
    parameter int SCORE_DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            inc,
    output logic [BCD_W*SCORE_DIGITS-1:0]   score
);

    logic [BCD_W*SCORE_DIGITS-1:0] score_q, score_d;
    logic [SCORE_DIGITS:0]         carry;

    // Carry chain across digits; a carry out of the top digit means the
    // score is already all nines, so the increment is dropped.
    always_comb begin
        score_d  = score_q;
        carry    = '0;
        carry[0] = inc;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry[i]) begin
                if (score_q[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
                    score_d[i*BCD_W +: BCD_W] = '0;
                    carry[i+1]                = 1'b1;
                end else begin
                    score_d[i*BCD_W +: BCD_W] = score_q[i*BCD_W +: BCD_W] + BCD_W'(1);
                end
            end
        end
        if (clear) begin
            score_d = '0;
        end else if (carry[SCORE_DIGITS]) begin
            score_d = score_q;
        end
    end

    // Score register.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the snake VGA design: lives, BCD score, level
// progression with snake speed-up, pause, and timed death/game-over phases.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | waiting for any direction button to start a game
// ST_PLAY      | snake running; steps, apples and collisions handled
// ST_PAUSE     | everything frozen until the next pause edge
// ST_DYING     | lost a life; wait DEATH_FRAMES frames, then respawn
// ST_GAME_OVER | no lives left; wait DEATH_FRAMES frames, then idle
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int LIVES            = 3,
    parameter int SCORE_DIGITS     = 3,
    parameter int APPLES_PER_LEVEL = 5,
    parameter int MAX_LEVEL        = 7,
    parameter int START_PERIOD     = 8,
    parameter int DEATH_FRAMES     = 60
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [3:0]                         dir_btn,
    input  logic                               pause_btn,
    input  logic [1:0]                         collision_state,
    input  logic                               frame_tick,
    output logic [2:0]                         game_state,
    output logic                               step_en,
    output logic                               apple_trigger,
    output logic                               snake_reset,
    output logic [4*SCORE_DIGITS-1:0]          score,
    output logic [2:0]                         lives,
    output logic [$clog2(MAX_LEVEL+1)-1:0]     level
);

    localparam int LVL_W = $clog2(MAX_LEVEL + 1);
    localparam int DIV_W = $clog2(START_PERIOD + 1);
    localparam int APP_W = $clog2(APPLES_PER_LEVEL + 1);
    localparam int DTH_W = $clog2(DEATH_FRAMES + 1);

    game_state_e        state_q;
    logic [2:0]         lives_q;
    logic [LVL_W-1:0]   level_q;
    logic [APP_W-1:0]   apple_cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic [DTH_W-1:0]   death_cnt_q;
    logic               ev_latch_q;
    logic               pause_prev_q;
    logic               step_en_q;
    logic               apple_trig_q;
    logic               snake_reset_q;

    logic               pause_edge;
    logic               ev_new;
    logic               play_act;
    logic               hit;
    logic               apple;
    logic               start;
    logic [DIV_W-1:0]   step_target;

    // A pause edge in PLAY wins over everything else that cycle, so an
    // event or frame tick landing on it is simply not acted on.
    assign pause_edge  = pause_btn & ~pause_prev_q;
    assign ev_new      = (collision_state != COLL_NONE) && !ev_latch_q;
    assign play_act    = (state_q == ST_PLAY) && !pause_edge;
    assign hit         = play_act && ev_new && is_collision(collision_state);
    assign apple       = play_act && ev_new && (collision_state == APPLE_COLLECTED);
    assign start       = (state_q == ST_IDLE) && (dir_btn != 4'b0000);
    assign step_target = DIV_W'(START_PERIOD - 1 - int'(level_q));

    bcd_score_counter #(
        .SCORE_DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (apple),
        .score (score)
    );

    // Game FSM with its counters and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lives_q       <= 3'(LIVES);
            level_q       <= '0;
            apple_cnt_q   <= '0;
            div_q         <= '0;
            death_cnt_q   <= '0;
            ev_latch_q    <= 1'b0;
            pause_prev_q  <= 1'b0;
            step_en_q     <= 1'b0;
            apple_trig_q  <= 1'b0;
            snake_reset_q <= 1'b0;
        end else begin
            step_en_q     <= 1'b0;
            apple_trig_q  <= 1'b0;
            snake_reset_q <= 1'b0;
            pause_prev_q  <= pause_btn;

            if (frame_tick) begin
                ev_latch_q <= 1'b0;
            end else if (play_act && ev_new) begin
                ev_latch_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q       <= ST_PLAY;
                        lives_q       <= 3'(LIVES);
                        level_q       <= '0;
                        apple_cnt_q   <= '0;
                        div_q         <= '0;
                        snake_reset_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (pause_edge) begin
                        state_q <= ST_PAUSE;
                    end else if (hit) begin
                        lives_q     <= lives_q - 3'd1;
                        state_q     <= (lives_q == 3'd1) ? ST_GAME_OVER : ST_DYING;
                        death_cnt_q <= DTH_W'(DEATH_FRAMES - 1);
                    end else begin
                        if (apple) begin
                            apple_trig_q <= 1'b1;
                            if (apple_cnt_q == APP_W'(APPLES_PER_LEVEL - 1)) begin
                                apple_cnt_q <= '0;
                                if (level_q < LVL_W'(MAX_LEVEL)) begin
                                    level_q <= level_q + LVL_W'(1);
                                end
                            end else begin
                                apple_cnt_q <= apple_cnt_q + APP_W'(1);
                            end
                        end
                        if (frame_tick) begin
                            if (div_q == step_target) begin
                                step_en_q <= 1'b1;
                                div_q     <= '0;
                            end else begin
                                div_q <= div_q + DIV_W'(1);
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_edge) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        if (death_cnt_q == '0) begin
                            state_q       <= ST_PLAY;
                            snake_reset_q <= 1'b1;
                            div_q         <= '0;
                        end else begin
                            death_cnt_q <= death_cnt_q - DTH_W'(1);
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (frame_tick) begin
                        if (death_cnt_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            death_cnt_q <= death_cnt_q - DTH_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign game_state    = state_q;
    assign step_en       = step_en_q;
    assign apple_trigger = apple_trig_q;
    assign snake_reset   = snake_reset_q;
    assign lives         = lives_q;
    assign level         = level_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed game scenarios plus a random phase,
// every cycle compared against a score/lives/level model kept in plain integers.
module tb_snake_game_ctrl;

    localparam int LIVES = 3;
    localparam int SD    = 3;
    localparam int APL   = 5;
    localparam int MAXL  = 7;
    localparam int SP    = 8;
    localparam int DF    = 60;
    localparam int MAX_SCORE = 999;

    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DYING = 3;
    localparam int S_GO    = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  dir_btn = 4'b0;
    logic        pause_btn = 1'b0;
    logic [1:0]  collision_state = 2'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  game_state;
    logic        step_en;
    logic        apple_trigger;
    logic        snake_reset;
    logic [11:0] score;
    logic [2:0]  lives;
    logic [2:0]  level;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .LIVES(LIVES), .SCORE_DIGITS(SD), .APPLES_PER_LEVEL(APL),
        .MAX_LEVEL(MAXL), .START_PERIOD(SP), .DEATH_FRAMES(DF)
    ) dut (
        .clk(clk), .reset(reset), .dir_btn(dir_btn), .pause_btn(pause_btn),
        .collision_state(collision_state), .frame_tick(frame_tick),
        .game_state(game_state), .step_en(step_en), .apple_trigger(apple_trigger),
        .snake_reset(snake_reset), .score(score), .lives(lives), .level(level)
    );

    int errors = 0;
    int checks = 0;
    int cycn = 0;

    // Reference model state: plain counts, not the controller's registers.
    int m_state, m_score, m_lives, m_apples, m_ticks, m_death;
    bit m_latch, m_pprev;
    bit e_step, e_apple, e_sreset;

    int obs_steps = 0, obs_apples = 0, obs_sresets = 0;
    bit pl = 1'b0;

    function automatic int m_level();
        return (m_apples / APL > MAXL) ? MAXL : m_apples / APL;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] d, input logic p,
                              input logic [1:0] c, input logic ft);
        bit pedge, ev, latch_set;
        int lvl;
        e_step = 0; e_apple = 0; e_sreset = 0; latch_set = 0;
        if (r) begin
            m_state = S_IDLE; m_score = 0; m_lives = LIVES; m_apples = 0;
            m_ticks = 0; m_death = 0; m_latch = 0; m_pprev = 0;
            return;
        end
        pedge   = p && !m_pprev;
        m_pprev = p;
        ev      = (c != 2'b00) && !m_latch;
        lvl     = m_level();
        case (m_state)
            S_IDLE: begin
                if (d != 4'b0) begin
                    m_state = S_PLAY; m_score = 0; m_apples = 0; m_ticks = 0;
                    m_lives = LIVES; e_sreset = 1;
                end
            end
            S_PLAY: begin
                if (pedge) begin
                    m_state = S_PAUSE;
                end else begin
                    latch_set = ev;
                    if (ev && c != 2'b10) begin
                        m_lives = m_lives - 1;
                        m_state = (m_lives == 0) ? S_GO : S_DYING;
                        m_death = 0;
                    end else begin
                        if (ev) begin
                            e_apple = 1;
                            if (m_score < MAX_SCORE) m_score++;
                            m_apples++;
                        end
                        if (ft) begin
                            m_ticks++;
                            if (m_ticks >= SP - lvl) begin
                                e_step = 1;
                                m_ticks = 0;
                            end
                        end
                    end
                end
            end
            S_PAUSE: if (pedge) m_state = S_PLAY;
            S_DYING, S_GO: begin
                if (ft) begin
                    m_death++;
                    if (m_death == DF) begin
                        m_death = 0;
                        if (m_state == S_DYING) begin
                            m_state = S_PLAY; e_sreset = 1; m_ticks = 0;
                        end else begin
                            m_state = S_IDLE;
                        end
                    end
                end
            end
            default: m_state = S_IDLE;
        endcase
        m_latch = ft ? 1'b0 : (m_latch | latch_set);
    endtask

    task automatic cyc(input logic r, input logic [3:0] d, input logic p,
                       input logic [1:0] c, input logic ft);
        logic [2:0] es, el, elv;
        logic [31:0] exp, obs;
        @(negedge clk);
        reset = r; dir_btn = d; pause_btn = p; collision_state = c; frame_tick = ft;
        @(posedge clk);
        #1;
        cycn++;
        model_step(r, d, p, c, ft);
        es  = 3'(m_state);
        el  = 3'(m_lives);
        elv = 3'(m_level());
        exp = {8'h0, es, e_step, e_apple, e_sreset, to_bcd(m_score), el, elv};
        obs = {8'h0, game_state, step_en, apple_trigger, snake_reset, score, lives, level};
        check($sformatf("outputs@cyc%0d", cycn), obs, exp);
        if (step_en)       obs_steps++;
        if (apple_trigger) obs_apples++;
        if (snake_reset)   obs_sresets++;
    endtask

    task automatic nop();                      cyc(0, 4'b0, pl, 2'b00, 0); endtask
    task automatic tick();                     cyc(0, 4'b0, pl, 2'b00, 1); endtask
    task automatic coll(input logic [1:0] c);  cyc(0, 4'b0, pl, c, 0);     endtask
    task automatic press(input logic [3:0] d); cyc(0, d, pl, 2'b00, 0);    endtask

    task automatic ticks_to_step(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n++;
            if (step_en) break;
        end
    endtask

    initial begin
        int n, s0, a0, r0;
        logic [1:0] rc;
        int rv;

        // Reset state
        cyc(1, 4'b0, 0, 2'b00, 0);
        cyc(1, 4'b0, 0, 2'b00, 0);
        nop();
        check("reset_state", 32'(game_state), 32'(3'b000));
        check("reset_lives", 32'(lives), 32'd3);

        // Game start
        press(4'b0001);
        check("start_state", 32'(game_state), 32'(3'b001));
        check("start_snake_reset", 32'(snake_reset), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_score", 32'(score), 32'h000);
        nop();
        check("snake_reset_one_pulse", 32'(snake_reset), 32'd0);

        // Level 0 cadence: one step per 8 ticks
        s0 = obs_steps;
        for (int i = 0; i < 24; i++) begin
            nop();
            tick();
        end
        check("step_on_8th_tick", 32'(step_en), 32'd1);
        check("steps_in_24_ticks", 32'(obs_steps - s0), 32'd3);

        // Apple held for 20 cycles within one frame
        a0 = obs_apples;
        for (int i = 0; i < 20; i++) coll(2'b10);
        check("apple_once_per_frame", 32'(obs_apples - a0), 32'd1);
        check("score_after_one_apple", 32'(score), 32'h001);
        tick();

        // Four more apples -> level 1, period 7
        for (int i = 0; i < 4; i++) begin
            coll(2'b10);
            tick();
        end
        check("level_after_5_apples", 32'(level), 32'd1);
        ticks_to_step(n);
        check("ticks_to_first_l1_step", 32'(n), 32'd2);
        ticks_to_step(n);
        check("level1_period", 32'(n), 32'd7);

        // Pause: frozen divider and ignored collisions
        for (int i = 0; i < 3; i++) tick();
        pl = 1; nop();
        check("pause_entered", 32'(game_state), 32'(3'b010));
        for (int i = 0; i < 3; i++) coll(2'b01);
        for (int i = 0; i < 5; i++) begin
            tick();
            nop();
        end
        check("pause_lives_kept", 32'(lives), 32'd3);
        pl = 0; nop();
        check("pause_release_no_edge", 32'(game_state), 32'(3'b010));
        pl = 1; nop();
        check("pause_exit", 32'(game_state), 32'(3'b001));
        pl = 0; nop();
        ticks_to_step(n);
        check("step_after_resume", 32'(n), 32'd4);

        // Deaths down to game over
        for (int k = 0; k < 2; k++) begin
            coll(2'b01);
            check($sformatf("dying_state_%0d", k), 32'(game_state), 32'(3'b011));
            check($sformatf("dying_lives_%0d", k), 32'(lives), 32'(2 - k));
            for (int i = 0; i < DF - 1; i++) begin
                nop();
                tick();
            end
            check($sformatf("still_dying_%0d", k), 32'(game_state), 32'(3'b011));
            r0 = obs_sresets;
            tick();
            check($sformatf("respawn_state_%0d", k), 32'(game_state), 32'(3'b001));
            check($sformatf("respawn_pulse_%0d", k), 32'(obs_sresets - r0), 32'd1);
            nop();
        end
        coll(2'b11);
        check("game_over_state", 32'(game_state), 32'(3'b111));
        check("game_over_lives", 32'(lives), 32'd0);
        for (int i = 0; i < DF - 1; i++) begin
            pl = ~pl;
            press(4'b1000);
            tick();
        end
        pl = 0;
        check("still_game_over", 32'(game_state), 32'(3'b111));
        tick();
        check("back_to_idle", 32'(game_state), 32'(3'b000));
        check("score_held_in_idle", 32'(score), 32'h005);

        // Score saturation and level saturation
        press(4'b0010);
        check("restart_score_clear", 32'(score), 32'h000);
        for (int i = 0; i < MAX_SCORE; i++) begin
            coll(2'b10);
            tick();
        end
        check("score_999", 32'(score), 32'h999);
        for (int i = 0; i < 3; i++) begin
            coll(2'b10);
            tick();
        end
        check("score_saturates", 32'(score), 32'h999);
        check("level_saturates", 32'(level), 32'(MAXL));

        // Random phase against the model
        for (int i = 0; i < 4000; i++) begin
            rv = int'($urandom_range(0, 99));
            rc = (rv < 3) ? 2'b01 : (rv < 4) ? 2'b11 : (rv < 20) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 39) == 0) pl = ~pl;
            cyc(($urandom_range(0, 799) == 0),
                ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0,
                pl, rc, ($urandom_range(0, 3) == 0));
        end
        pl = 0;

        // Reset during DYING
        cyc(1, 4'b0, 0, 2'b00, 0);
        press(4'b0001);
        coll(2'b01);
        check("pre_reset_dying", 32'(game_state), 32'(3'b011));
        cyc(1, 4'b1111, 1, 2'b10, 1);
        check("reset_mid_state", 32'(game_state), 32'(3'b000));
        check("reset_mid_lives", 32'(lives), 32'd3);
        check("reset_mid_score", 32'(score), 32'h000);
        check("reset_mid_pulses", 32'({step_en, apple_trigger, snake_reset}), 32'd0);
        nop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Parametrised game-flow controller for the snake VGA design. It replaces the minimal IDLE/PLAY/GAME_OVER logic in the top level and adds lives, a BCD score, level progression with snake speed-up, pause, and timed death/game-over phases. It sits between the collision detector, the debounced buttons and frame timing on one side, and the snake, apple and score-display logic on the other.

Parameters:
LIVES, 3, lives at game start (1..7)
SCORE_DIGITS, 3, number of BCD score digits
APPLES_PER_LEVEL, 5, apples per level increment
MAX_LEVEL, 7, level saturation value
START_PERIOD, 8, frames per snake step at level 0; must be > MAX_LEVEL
DEATH_FRAMES, 60, frames spent in DYING and in GAME_OVER

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
dir_btn  in  4  debounced up/down/left/right levels
pause_btn  in  1  debounced pause level
collision_state  in  2  01=COLLISION, 10=APPLE_COLLECTED, 11 treated as COLLISION, 00=none
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
game_state  out  3  IDLE=000, PLAY=001, PAUSE=010, DYING=011, GAME_OVER=111
step_en  out  1  one-cycle snake-advance pulse
apple_trigger  out  1  one-cycle new-apple pulse
snake_reset  out  1  one-cycle pulse to re-initialise the snake
score  out  4*SCORE_DIGITS  BCD score, digit 0 in LSBs
lives  out  3  remaining lives
level  out  $clog2(MAX_LEVEL+1)  current level

Behaviour:
- Reset: game_state=IDLE, score=0, lives=LIVES, level=0, every pulse output 0, all internal counters 0.
- All outputs are registered. An event sampled at cycle N takes effect at cycle N+1.
- IDLE: any dir_btn bit high -> PLAY. On that transition, clear score, apple counter, level and frame divider, load lives=LIVES, and pulse snake_reset.
- PLAY, collision handling: act only on the first non-00 collision_state in each frame. A per-frame event latch is set by the first event and cleared on frame_tick; later events in the same frame are ignored.
- PLAY, COLLISION: decrement lives. If the result is 0 -> GAME_OVER, else -> DYING. Clear the frame counter.
- PLAY, APPLE_COLLECTED:
  - Pulse apple_trigger.
  - Increment score as BCD with ripple carry across digits; saturate at all nines with no wrap.
  - Increment the apple counter. When it reaches APPLES_PER_LEVEL, set it to 0 and increment level, saturating at MAX_LEVEL.
- step_en: pulse only in PLAY, on the frame_tick that makes the frame divider equal START_PERIOD-level-1; the divider then returns to 0.
  - A level change takes effect from the next step.
  - If a step frame_tick and an apple event occur in the same cycle, both are processed.
- Pause: a pause_btn rising edge (previous-value register) toggles PLAY<->PAUSE.
  - PAUSE freezes the frame divider and ignores collisions.
  - Leaving PAUSE resumes the divider from its held value.
  - A pause edge in any other state is ignored.
- DYING: count DEATH_FRAMES frame_ticks, then -> PLAY with a snake_reset pulse and a cleared divider. Score and level are kept.
- GAME_OVER: count DEATH_FRAMES frame_ticks, then -> IDLE. Score is held until the next game start.
- Button presses in DYING/GAME_OVER are ignored.
- Reset asserted mid-game overrides everything on the next edge and produces no pulses.

Decomposition:
- Shared package snake_pkg holds the state encodings, the collision codes COLLISION/APPLE_COLLECTED, and the BCD digit width.
- Sub-module bcd_score_counter: parametrised SCORE_DIGITS, with inputs clk, reset, clear, inc and output score. Carry is chained combinationally and the output is registered; it saturates at all nines.

Test Plan:
- Reset, then dir_btn=0001 for one cycle -> game_state 001 next cycle, snake_reset one pulse, lives=3, score=000.
- Level 0, START_PERIOD=8 -> step_en exactly every 8th frame_tick. After 5 apples -> level=1 and step_en every 7th frame_tick.
- collision_state=10 held for 20 cycles within one frame -> exactly one apple_trigger, score 000->001. Score preset to 999 plus one apple -> stays 999.
- collision_state=01 with lives=3 -> DYING, lives=2. After 60 frame_ticks -> PLAY with a snake_reset pulse. Repeat until lives=0 -> GAME_OVER, then IDLE after 60 frames.
- pause_btn rising edge in PLAY -> PAUSE; collision_state=01 during PAUSE -> no lives change. Second edge -> PLAY, and the step cadence resumes with no missed or extra step.
- reset asserted during DYING -> next cycle IDLE, lives=3, score=0, no pulses.
